// File: rtl/alu_pkg.sv
// Shared definitions for the ARM-style ALU: opcode encoding and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        AND = 4'b0000,
        EOR = 4'b0001,
        SUB = 4'b0010,
        RSB = 4'b0011,
        ADD = 4'b0100,
        ADC = 4'b0101,
        SBC = 4'b0110,
        RSC = 4'b0111,
        TST = 4'b1000,
        TEQ = 4'b1001,
        CMP = 4'b1010,
        CMN = 4'b1011,
        ORR = 4'b1100,
        MOV = 4'b1101,
        BIC = 4'b1110,
        MVN = 4'b1111
    } alu_op_e;

    // Bit positions inside ALUFlags = {N,Z,C,V}
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    // Opcodes that feed the adder with ~Y instead of Y
    function automatic logic is_sub_type(input logic [3:0] op);
        return (op == SUB) || (op == RSB) || (op == SBC) || (op == RSC) || (op == CMP);
    endfunction

endpackage

// File: rtl/alu_adder.sv
// 32-bit ripple-free behavioural adder with carry-in and carry-out.
module alu_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};

endmodule

// File: rtl/alu.sv
// Combinational ARM data-processing ALU; clk/reset are present for integration only.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  ALUControl,
    input  logic        carry,
    output logic [31:0] ALUResult,
    output logic [3:0]  ALUFlags
);

    logic [31:0] w_x;
    logic [31:0] w_y;
    logic [31:0] condinvb;
    logic        carryin;
    logic [31:0] sum;
    logic        w_cout;
    logic        w_swap;
    logic        w_arith_v;
    logic        w_unused;

    // The ALU holds no state, so clock and reset are intentionally sunk here.
    assign w_unused = clk ^ reset;

    assign w_swap   = (ALUControl == RSB) || (ALUControl == RSC);
    assign w_x      = w_swap ? SrcB : SrcA;
    assign w_y      = w_swap ? SrcA : SrcB;
    assign condinvb = is_sub_type(ALUControl) ? ~w_y : w_y;

    always_comb begin
        carryin = 1'b0;
        case (ALUControl)
            SUB, RSB, CMP:  carryin = 1'b1;
            ADC, SBC, RSC:  carryin = carry;
            default:        carryin = 1'b0;
        endcase
    end

    alu_adder u_adder (
        .i_a    (w_x),
        .i_b    (condinvb),
        .i_cin  (carryin),
        .o_sum  (sum),
        .o_cout (w_cout)
    );

    // Signed overflow: operands agree in sign but the sum does not.
    assign w_arith_v = (w_x[31] == condinvb[31]) && (sum[31] != w_x[31]);

    always_comb begin
        ALUResult = 32'd0;
        ALUFlags  = 4'b0000;
        case (ALUControl)
            AND, TST: begin
                ALUResult   = SrcA & SrcB;
                ALUFlags[C] = carry;
            end
            EOR, TEQ: begin
                ALUResult   = SrcA ^ SrcB;
                ALUFlags[C] = carry;
            end
            ORR: begin
                ALUResult   = SrcA | SrcB;
                ALUFlags[C] = carry;
            end
            MOV: begin
                ALUResult   = SrcB;
                ALUFlags[C] = carry;
            end
            BIC: begin
                ALUResult   = SrcA & ~SrcB;
                ALUFlags[C] = carry;
            end
            MVN: begin
                ALUResult   = ~SrcB;
                ALUFlags[C] = carry;
            end
            SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN: begin
                ALUResult   = sum;
                ALUFlags[C] = w_cout;
                ALUFlags[V] = w_arith_v;
            end
            default: begin
                ALUResult = 32'd0;
                ALUFlags  = 4'b0000;
            end
        endcase
        if (ALUControl inside {[4'b0000:4'b1111]}) begin
            ALUFlags[N] = ALUResult[31];
            ALUFlags[Z] = (ALUResult == 32'd0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner vectors then randomized ops against a wide-integer model.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  ALUControl;
    logic        carry;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;

    int n_checks = 0;
    int n_fail   = 0;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .carry      (carry),
        .ALUResult  (ALUResult),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed/unsigned 64-bit arithmetic straight from the opcode table.
    function automatic void model(input logic [3:0] op, input logic cin, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, ures, sres;
        logic   is_arith, cf, vf;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        is_arith = 1'b1;
        ures = 0; sres = 0; r = 32'd0;
        case (op)
            4'b0000, 4'b1000: begin r = a & b;  is_arith = 1'b0; end
            4'b0001, 4'b1001: begin r = a ^ b;  is_arith = 1'b0; end
            4'b1100:          begin r = a | b;  is_arith = 1'b0; end
            4'b1101:          begin r = b;      is_arith = 1'b0; end
            4'b1110:          begin r = a & ~b; is_arith = 1'b0; end
            4'b1111:          begin r = ~b;     is_arith = 1'b0; end
            4'b0100, 4'b1011: begin ures = ua + ub;             sres = sa + sb; end
            4'b0101:          begin ures = ua + ub + cin;       sres = sa + sb + cin; end
            4'b0010, 4'b1010: begin ures = ua - ub;             sres = sa - sb; end
            4'b0110:          begin ures = ua - ub - (1 - cin); sres = sa - sb - (1 - cin); end
            4'b0011:          begin ures = ub - ua;             sres = sb - sa; end
            4'b0111:          begin ures = ub - ua - (1 - cin); sres = sb - sa - (1 - cin); end
            default:          begin r = 32'd0; is_arith = 1'b0; end
        endcase
        if (is_arith) begin
            r = ures[31:0];
            // Adds carry when the unsigned total exceeds 32 bits; subtracts carry when no borrow occurs.
            if (op inside {4'b0100, 4'b0101, 4'b1011})
                cf = (ures > 64'sh0_FFFF_FFFF);
            else
                cf = (ures >= 0);
            vf = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
        end else begin
            cf = cin;
            vf = 1'b0;
        end
        f = {r[31], (r == 32'd0), cf, vf};
    endfunction

    task automatic apply(input logic [3:0] op, input logic cin, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        @(posedge clk);
        #1;
        ALUControl = op; carry = cin; SrcA = a; SrcB = b; reset = rst;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_r, input logic [3:0] exp_f);
        @(negedge clk);
        n_checks++;
        assert (ALUResult === exp_r) else begin
            n_fail++;
            $error("FAIL %s result op=%b cin=%b a=%h b=%h got=%h want=%h",
                   tag, ALUControl, carry, SrcA, SrcB, ALUResult, exp_r);
        end
        n_checks++;
        assert (ALUFlags === exp_f) else begin
            n_fail++;
            $error("FAIL %s flags op=%b cin=%b a=%h b=%h got=%b want=%b",
                   tag, ALUControl, carry, SrcA, SrcB, ALUFlags, exp_f);
        end
        $display("%s op=%b cin=%b a=%h b=%h rst=%b -> res=%h flags=%b", tag, ALUControl, carry,
                 SrcA, SrcB, reset, ALUResult, ALUFlags);
    endtask

    task automatic directed(input string tag, input logic [3:0] op, input logic cin,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_r, input logic [3:0] exp_f);
        apply(op, cin, a, b, 1'b0);
        check(tag, exp_r, exp_f);
    endtask

    initial begin
        logic [31:0] a, b, mr;
        logic [3:0]  op, mf;
        logic        cin, rst;

        reset = 1'b1; SrcA = '0; SrcB = '0; ALUControl = 4'b0100; carry = 1'b0;
        // Outputs depend on inputs even while reset is held.
        apply(4'b0100, 1'b0, 32'h0000_0002, 32'h0000_0003, 1'b1);
        check("reset_add", 32'h0000_0005, 4'b0000);

        directed("add_wrap",  4'b0100, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        directed("add_ovf",   4'b0100, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        directed("sub_neg",   4'b0010, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000);
        directed("adc_c1",    4'b0101, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 4'b0000);
        directed("sbc_c0",    4'b0110, 1'b0, 32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 4'b0010);
        directed("rsb",       4'b0011, 1'b0, 32'h0000_0003, 32'h0000_000A, 32'h0000_0007, 4'b0010);
        directed("bic",       4'b1110, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000, 4'b1010);
        directed("mvn",       4'b1111, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1010);
        directed("tst",       4'b1000, 1'b1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 4'b0110);
        directed("cmp_eq",    4'b1010, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0110);
        directed("sub_vneg",  4'b0010, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);

        // Adder internals are probed by name from outside.
        apply(4'b0011, 1'b0, 32'h0000_0003, 32'h0000_000A, 1'b0);
        @(negedge clk);
        n_checks++;
        assert (dut.sum === 32'h0000_0007 && dut.carryin === 1'b1 && dut.condinvb === 32'hFFFF_FFFC) else begin
            n_fail++;
            $error("FAIL probe got sum=%h carryin=%b condinvb=%h want 00000007/1/fffffffc",
                   dut.sum, dut.carryin, dut.condinvb);
        end

        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            rst = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'h7FFF_FFFF;
                1:       b = a;
                default: b = $urandom;
            endcase
            model(op, cin, a, b, mr, mf);
            apply(op, cin, a, b, rst);
            check($sformatf("rnd%0d", i), mr, mf);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
